// File: rtl/serial_tc_recv_if.sv
// Link between the serial complementer output and the receive end:
// serial bit stream in one direction, recovered parallel words back.
interface serial_tc_recv_if #(
  parameter int WIDTH = 8
);
  logic             bit_in;
  logic             bit_vld;
  logic             start;
  logic [WIDTH-1:0] word_out;
  logic [WIDTH-1:0] orig_out;
  logic             word_vld;
  logic             busy;
  logic             frame_err;

  modport master (
    output bit_in, bit_vld, start,
    input  word_out, orig_out, word_vld, busy, frame_err
  );

  modport slave (
    input  bit_in, bit_vld, start,
    output word_out, orig_out, word_vld, busy, frame_err
  );
endinterface

// File: rtl/serial_tc_recv.sv
// Deserializes LSB-first WIDTH-bit frames and, in the same pass, serially
// re-complements them to recover the original two's-complement operand.
module serial_tc_recv #(
  parameter int WIDTH = 8
) (
  input  logic             t_clock,
  input  logic             r_n,
  serial_tc_recv_if.slave  link
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [0:0]    IDLE = 1'b0;
  localparam logic [0:0]    RECV = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0] raw_reg, raw_next;
  logic [WIDTH-1:0] dec_reg, dec_next;
  logic             seen_reg, seen_next;
  logic [WIDTH-1:0] word_reg, orig_reg;
  logic             word_vld_reg, frame_err_reg;

  logic          accept, first, done, abort, seen_eff, dec_bit;
  logic [CW-1:0] idx;

  // A start bit is only honoured together with bit_vld; in IDLE nothing else is accepted.
  assign accept   = link.bit_vld && (link.start || (state_reg == RECV));
  assign first    = link.start;
  assign abort    = link.bit_vld && link.start && (state_reg == RECV);
  assign done     = accept && !first && (count_reg == LAST);
  assign seen_eff = first ? 1'b0 : seen_reg;
  assign dec_bit  = seen_eff ? ~link.bit_in : link.bit_in;
  assign idx      = first ? '0 : count_reg;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    raw_next   = raw_reg;
    dec_next   = dec_reg;
    seen_next  = seen_reg;
    if (accept) begin
      if (first) begin
        raw_next = '0;
        dec_next = '0;
      end
      raw_next[idx] = link.bit_in;
      dec_next[idx] = dec_bit;
      seen_next     = seen_eff | link.bit_in;
      if (done) begin
        state_next = IDLE;
        count_next = '0;
      end else begin
        state_next = RECV;
        count_next = idx + CW'(1);
      end
    end
  end

  always_ff @(posedge t_clock or negedge r_n) begin
    if (!r_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      raw_reg       <= '0;
      dec_reg       <= '0;
      seen_reg      <= 1'b0;
      word_reg      <= '0;
      orig_reg      <= '0;
      word_vld_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      raw_reg       <= raw_next;
      dec_reg       <= dec_next;
      seen_reg      <= seen_next;
      word_vld_reg  <= done;
      frame_err_reg <= abort;
      if (done) begin
        word_reg <= raw_next;
        orig_reg <= dec_next;
      end
    end
  end

  assign link.word_out  = word_reg;
  assign link.orig_out  = orig_reg;
  assign link.word_vld  = word_vld_reg;
  assign link.busy      = (state_reg == RECV);
  assign link.frame_err = frame_err_reg;
endmodule

// File: tb/tb_serial_tc_recv.sv
// Directed bench for serial_tc_recv (WIDTH=8): expected words are queued as
// frames are driven and popped by a monitor when word_vld pulses.
module tb_serial_tc_recv;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   vld_count = 0;
  int   ferr_count = 0;
  logic [2*W-1:0] exp_q[$];

  serial_tc_recv_if #(.WIDTH(W)) bus ();

  serial_tc_recv #(.WIDTH(W)) dut (
    .t_clock (clk),
    .r_n     (rst_n),
    .link    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] neg(input logic [W-1:0] w);
    return W'(~w + W'(1));
  endfunction

  // Monitor: one line per completed word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_err) ferr_count++;
      if (bus.word_vld || bus.frame_err)
        chk("vld_err_exclusive", {31'd0, bus.word_vld & bus.frame_err}, 32'd0);
      if (bus.word_vld) begin
        logic [2*W-1:0] e;
        vld_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word_vld", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("word: word_out=%02h orig_out=%02h (expected %02h/%02h)",
                   bus.word_out, bus.orig_out, e[2*W-1:W], e[W-1:0]);
          chk("word_out", 32'(bus.word_out), 32'(e[2*W-1:W]));
          chk("orig_out", 32'(bus.orig_out), 32'(e[W-1:0]));
        end
      end
    end
  end

  task automatic send_bit(input logic b, input logic s);
    @(posedge clk); #1;
    bus.bit_in = b; bus.start = s; bus.bit_vld = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.bit_vld = 1'b0; bus.start = 1'b0; bus.bit_in = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input int maxgap);
    exp_q.push_back({w, neg(w)});
    for (int i = 0; i < W; i++) begin
      if (maxgap > 0) repeat ($urandom_range(maxgap, 0)) idle_cycle();
      send_bit(w[i], i == 0);
    end
  endtask

  task automatic settle();
    idle_cycle();
    idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    int v0;
    bus.bit_in = 1'b0; bus.bit_vld = 1'b0; bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_word_out", 32'(bus.word_out), 32'd0);
    chk("reset_orig_out", 32'(bus.orig_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_word_vld", 32'(bus.word_vld), 32'd0);
    #1 rst_n = 1'b1;

    // 0x05 contiguous, then check the pulse lands one cycle after bit 7
    send_frame(8'h05, 0);
    @(negedge clk);
    chk("busy_last_bit", 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk("pulse_latency", 32'(bus.word_vld), 32'd1);
    chk("busy_after_05", 32'(bus.busy), 32'd0);
    settle();
    chk("count_05", 32'(vld_count), 32'd1);

    // back-to-back 0x80 and 0x00
    send_frame(8'h80, 0);
    send_frame(8'h00, 0);
    settle();
    chk("count_b2b", 32'(vld_count), 32'd3);

    // 0xB4 with random gaps
    send_frame(8'hB4, 3);
    settle();
    chk("count_gaps", 32'(vld_count), 32'd4);

    // abort after 4 bits, then 0x01
    send_bit(1'b1, 1'b1);
    for (int i = 1; i < 4; i++) send_bit(1'(i & 1), 1'b0);
    @(negedge clk);
    chk("busy_partial", 32'(bus.busy), 32'd1);
    send_frame(8'h01, 0);
    settle();
    chk("frame_err_count", 32'(ferr_count), 32'd1);
    chk("count_abort", 32'(vld_count), 32'd5);

    // reset after 5 bits, then 0x7F
    send_bit(1'b1, 1'b1);
    for (int i = 1; i < 5; i++) send_bit(1'b1, 1'b0);
    idle_cycle();
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_word_out", 32'(bus.word_out), 32'd0);
    chk("rst_orig_out", 32'(bus.orig_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_word_vld", 32'(bus.word_vld), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame(8'h7F, 0);
    settle();
    chk("count_rst", 32'(vld_count), 32'd6);

    // bit_vld without start in IDLE is ignored
    v0 = vld_count;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0);
      @(negedge clk);
      chk("idle_busy", 32'(bus.busy), 32'd0);
    end
    settle();
    chk("idle_no_vld", 32'(vld_count), 32'(v0));
    chk("idle_hold_word", 32'(bus.word_out), 32'h7F);
    chk("idle_hold_orig", 32'(bus.orig_out), 32'h81);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_err_total", 32'(ferr_count), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
